// File: rtl/enemy_sprite_gen.sv
// enemy_sprite_gen
//   Draws one animated enemy sprite into the video stream. A small FSM tracks
//   the enemy life cycle (HIDDEN -> WALK -> DYING -> HIDDEN). A 3-stage pixel
//   pipeline turns the scan position into a sprite ROM address and then into
//   an opaque/transparent colour decision.
//
//   Flow control: there are no handshakes. One pixel is accepted every clk
//   and the result for it appears exactly 3 clk later. rom_data must be the
//   ROM word for the rom_addr presented on the previous clk.
//
// Ports
//   clk, reset          pixel clock; asynchronous active-high reset
//   pixel_x, pixel_y    current scan position
//   video_on            visible-area qualifier
//   frame_tick          one-cycle pulse per video frame (animation time base)
//   enemy_x, enemy_y    sprite top-left corner
//   spawn, kill         one-cycle life-cycle requests
//   rom_addr, rom_data  sprite ROM interface (ROM read latency 1 clk)
//   enemy_on            output pixel is an opaque enemy pixel
//   enemy_rgb           colour of that pixel, 12'h000 when enemy_on=0
//   enemy_dead          registered "state is HIDDEN" flag
//   state_dbg           raw FSM state for debug: HIDDEN=0, WALK=1, DYING=2
module enemy_sprite_gen #(
   parameter int         SPR_W       = 64,
   parameter int         SPR_H       = 56,
   parameter int         FRAME_WORDS = 3584,
   parameter int         ANIM_DIV    = 8,
   parameter int         DEATH_TICKS = 30,
   parameter logic [11:0] TRANSPARENT = 12'h0F0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        frame_tick,
   input  logic [9:0]  enemy_x,
   input  logic [9:0]  enemy_y,
   input  logic        spawn,
   input  logic        kill,
   output logic [13:0] rom_addr,
   input  logic [11:0] rom_data,
   output logic        enemy_on,
   output logic [11:0] enemy_rgb,
   output logic        enemy_dead,
   output logic [1:0]  state_dbg
);

   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

   typedef enum logic [1:0] {
      HIDDEN = 2'd0,
      WALK   = 2'd1,
      DYING  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   anim_q, anim_d;
   logic            walk_frame_q, walk_frame_d;
   logic [DW-1:0]   death_q, death_d;

   // Pipeline signals
   logic            in_box;
   logic            in_box_d2;
   logic            hit;
   logic [1:0]      frame;
   logic [10:0]     x_end, y_end;
   logic [9:0]      dx, dy;
   logic [13:0]     addr;
   logic            opaque;

   assign state_dbg = state_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HIDDEN;
         anim_q       <= '0;
         walk_frame_q <= 1'b0;
         death_q      <= '0;
      end else begin
         state_q      <= state_d;
         anim_q       <= anim_d;
         walk_frame_q <= walk_frame_d;
         death_q      <= death_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d      = state_q;
      anim_d       = anim_q;
      walk_frame_d = walk_frame_q;
      death_d      = death_q;
      // spawn restarts the walk from any state and outranks kill
      if (spawn) begin
         state_d      = WALK;
         anim_d       = '0;
         walk_frame_d = 1'b0;
      end else begin
         case (state_q)
            WALK: begin
               if (kill) begin
                  state_d = DYING;
                  death_d = '0;
               end else if (frame_tick) begin
                  if (anim_q == AW'(ANIM_DIV - 1)) begin
                     anim_d       = '0;
                     walk_frame_d = ~walk_frame_q;
                  end else begin
                     anim_d = anim_q + AW'(1);
                  end
               end
            end
            DYING: begin
               if (frame_tick) begin
                  if (death_q == DW'(DEATH_TICKS - 1)) state_d = HIDDEN;
                  else                                 death_d = death_q + DW'(1);
               end
            end
            HIDDEN: ;
            default: state_d = HIDDEN;
         endcase
      end
   end

   // ---------------- Stage 1 address generation ----------------
   // Box edges are formed 11 bits wide so a sprite hanging past 1023 cannot
   // wrap around and show up at the left/top of the screen.
   always_comb begin
      frame = (state_q == DYING) ? 2'd2 : {1'b0, walk_frame_q};
      x_end = {1'b0, enemy_x} + 11'(SPR_W);
      y_end = {1'b0, enemy_y} + 11'(SPR_H);
      hit   = video_on && (state_q != HIDDEN) &&
              (pixel_x >= enemy_x) && ({1'b0, pixel_x} < x_end) &&
              (pixel_y >= enemy_y) && ({1'b0, pixel_y} < y_end);
      dx    = pixel_x - enemy_x;
      dy    = pixel_y - enemy_y;
      addr  = 14'(frame) * 14'(FRAME_WORDS) + 14'(dy) * 14'(SPR_W) + 14'(dx);
      opaque = in_box_d2 && (rom_data != TRANSPARENT);
   end

   // ---------------- Pixel pipeline and status ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_box     <= 1'b0;
         rom_addr   <= '0;
         in_box_d2  <= 1'b0;
         enemy_on   <= 1'b0;
         enemy_rgb  <= 12'h000;
         enemy_dead <= 1'b1;
      end else begin
         // stage 1: frame index is captured together with the pixel
         in_box     <= hit;
         rom_addr   <= hit ? addr : 14'd0;
         // stage 2: lines in_box up with the ROM read
         in_box_d2  <= in_box;
         // stage 3: colour-key test
         enemy_on   <= opaque;
         enemy_rgb  <= opaque ? rom_data : 12'h000;
         enemy_dead <= (state_q == HIDDEN);
      end
   end

endmodule

// File: tb/tb_enemy_sprite_gen.sv
module tb_enemy_sprite_gen;

   localparam int SPR_W       = 64;
   localparam int SPR_H       = 56;
   localparam int FRAME_WORDS = 3584;
   localparam int ANIM_DIV    = 8;
   localparam int DEATH_TICKS = 30;
   localparam logic [11:0] TRANSPARENT = 12'h0F0;
   localparam int ROM_WORDS   = 10752;
   localparam int M_HID = 0, M_WALK = 1, M_DIE = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        video_on = 1'b0, frame_tick = 1'b0;
   logic [9:0]  enemy_x = 10'd100, enemy_y = 10'd50;
   logic        spawn = 1'b0, kill = 1'b0;
   logic [13:0] rom_addr;
   logic [11:0] rom_data = 12'h000;
   logic        enemy_on;
   logic [11:0] enemy_rgb;
   logic        enemy_dead;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   enemy_sprite_gen dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on(video_on), .frame_tick(frame_tick), .enemy_x(enemy_x),
      .enemy_y(enemy_y), .spawn(spawn), .kill(kill), .rom_addr(rom_addr),
      .rom_data(rom_data), .enemy_on(enemy_on), .enemy_rgb(enemy_rgb),
      .enemy_dead(enemy_dead), .state_dbg(state_dbg)
   );

   // Sprite ROM with 1 clk read latency
   logic [11:0] rom_mem [0:ROM_WORDS-1];
   always @(posedge clk)
      rom_data <= (int'(rom_addr) < ROM_WORDS) ? rom_mem[rom_addr] : 12'h000;

   function automatic logic [11:0] rom_val(input int a);
      return (a < ROM_WORDS) ? rom_mem[a] : 12'h000;
   endfunction

   // ---------------- reference model ----------------
   // Tracks the enemy by elapsed ticks; frame and box follow from arithmetic.
   int          m_mode, m_walk_ticks, m_death_ticks;
   logic [13:0] exp_addr;
   logic        exp_dead;
   logic        on_p [3];
   logic [11:0] rgb_p [3];
   logic        exp_on;
   logic [11:0] exp_rgb;
   int          checks = 0, failures = 0;

   function automatic void model_reset();
      m_mode = M_HID; m_walk_ticks = 0; m_death_ticks = 0;
      exp_addr = '0; exp_dead = 1'b1;
      for (int i = 0; i < 3; i++) begin on_p[i] = 1'b0; rgb_p[i] = '0; end
      exp_on = 1'b0; exp_rgb = '0;
   endfunction

   // Driver: present one pixel plus control pulses for exactly one clk.
   task automatic step(input logic [9:0] px, input logic [9:0] py, input logic vo,
                       input logic ft, input logic sp, input logic kl);
      int         frm, a, prev_mode;
      bit         inb;
      logic [11:0] d;
      pixel_x = px; pixel_y = py; video_on = vo;
      frame_tick = ft; spawn = sp; kill = kl;
      frm = (m_mode == M_DIE) ? 2 : (m_walk_ticks / ANIM_DIV) % 2;
      inb = vo && (m_mode != M_HID) &&
            int'(px) >= int'(enemy_x) && int'(px) < int'(enemy_x) + SPR_W &&
            int'(py) >= int'(enemy_y) && int'(py) < int'(enemy_y) + SPR_H;
      a = inb ? (frm * FRAME_WORDS + (int'(py) - int'(enemy_y)) * SPR_W +
                 (int'(px) - int'(enemy_x))) % 16384 : 0;
      d = rom_val(a);
      @(posedge clk);
      prev_mode = m_mode;
      if (sp) begin
         m_mode = M_WALK; m_walk_ticks = 0;
      end else if (m_mode == M_WALK && kl) begin
         m_mode = M_DIE; m_death_ticks = 0;
      end else if (m_mode == M_WALK && ft) begin
         m_walk_ticks++;
      end else if (m_mode == M_DIE && ft) begin
         m_death_ticks++;
         if (m_death_ticks == DEATH_TICKS) m_mode = M_HID;
      end
      exp_dead = (prev_mode == M_HID);
      exp_addr = 14'(a);
      on_p[2] = on_p[1]; rgb_p[2] = rgb_p[1];
      on_p[1] = on_p[0]; rgb_p[1] = rgb_p[0];
      on_p[0] = inb && (d != TRANSPARENT);
      rgb_p[0] = on_p[0] ? d : 12'h000;
      exp_on = on_p[2]; exp_rgb = rgb_p[2];
      #1;
      frame_tick = 1'b0; spawn = 1'b0; kill = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rom_addr !== 14'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
      checks++; if (enemy_on !== 1'b0 || enemy_rgb !== 12'h000) begin failures++; $display("FAIL reset_pix got=%b/%h exp=0/000", enemy_on, enemy_rgb); end
      checks++; if (enemy_dead !== 1'b1) begin failures++; $display("FAIL reset_dead got=%b exp=1", enemy_dead); end
      reset = 1'b0;
   endtask

   task automatic test_no_spawn();
      int bad = 0;
      for (int i = 0; i < 200; i++) begin
         step(10'(100 + $urandom_range(0, 70)), 10'(50 + $urandom_range(0, 60)), 1'b1, 1'b0, 1'b0, 1'b0);
         if (enemy_on !== 1'b0 || rom_addr !== 14'd0 || enemy_dead !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL no_spawn_quiet got=%0d bad cycles exp=0", bad); end
   endtask

   task automatic test_box();
      enemy_x = 10'd100; enemy_y = 10'd50;
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0 || exp_addr !== 14'd0) begin failures++; $display("FAIL box_first got=%0d exp=0", rom_addr); end
      step(10'd163, 10'd105, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd3583) begin failures++; $display("FAIL box_last got=%0d exp=3583", rom_addr); end
      step(10'd164, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0) begin failures++; $display("FAIL box_right_addr got=%0d exp=0", rom_addr); end
      idle(2);
      checks++; if (enemy_on !== 1'b0 || enemy_on !== exp_on) begin failures++; $display("FAIL box_right_on got=%b exp=0", enemy_on); end
      checks++; if (enemy_dead !== 1'b0) begin failures++; $display("FAIL box_alive got=%b exp=0", enemy_dead); end
   endtask

   task automatic test_walk_anim();
      for (int i = 0; i < ANIM_DIV; i++) step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd3584 || exp_addr !== 14'd3584) begin failures++; $display("FAIL walk_frame1 got=%0d exp=3584", rom_addr); end
      for (int i = 0; i < ANIM_DIV - 1; i++) step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd3584) begin failures++; $display("FAIL walk_7ticks got=%0d exp=3584", rom_addr); end
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0) begin failures++; $display("FAIL walk_frame0 got=%0d exp=0", rom_addr); end
   endtask

   task automatic test_transparent();
      rom_mem[0] = TRANSPARENT;
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      checks++; if (enemy_on !== 1'b0 || enemy_rgb !== 12'h000) begin failures++; $display("FAIL key_hidden got=%b/%h exp=0/000", enemy_on, enemy_rgb); end
      rom_mem[0] = 12'hF00;
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      checks++; if (enemy_on !== 1'b0) begin failures++; $display("FAIL opaque_early got=%b exp=0", enemy_on); end
      idle(1);
      checks++; if (enemy_on !== 1'b1 || enemy_rgb !== 12'hF00) begin failures++; $display("FAIL opaque_pix got=%b/%h exp=1/f00", enemy_on, enemy_rgb); end
      idle(1);
      checks++; if (enemy_on !== 1'b0 || enemy_rgb !== 12'h000) begin failures++; $display("FAIL opaque_after got=%b/%h exp=0/000", enemy_on, enemy_rgb); end
   endtask

   task automatic test_kill_death();
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd7168) begin failures++; $display("FAIL dying_frame got=%0d exp=7168", rom_addr); end
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DEATH_TICKS - 1; i++) step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd7168 || enemy_dead !== 1'b0) begin failures++; $display("FAIL dying_29 got=%0d/%b exp=7168/0", rom_addr, enemy_dead); end
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (enemy_dead !== 1'b0) begin failures++; $display("FAIL dead_early got=%b exp=0", enemy_dead); end
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (enemy_dead !== 1'b1 || rom_addr !== 14'd0) begin failures++; $display("FAIL dead_done got=%b/%0d exp=1/0", enemy_dead, rom_addr); end
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0 || enemy_dead !== 1'b1) begin failures++; $display("FAIL kill_hidden got=%0d/%b exp=0/1", rom_addr, enemy_dead); end
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0 || enemy_dead !== 1'b0 || exp_dead !== 1'b0) begin failures++; $display("FAIL spawn_wins got=%0d/%b exp=0/0", rom_addr, enemy_dead); end
   endtask

   task automatic test_no_wrap();
      enemy_x = 10'd1000; enemy_y = 10'd50;
      rom_mem[10] = 12'h123;
      rom_mem[5 + 24] = 12'h456;
      step(10'd5, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0) begin failures++; $display("FAIL nowrap_addr got=%0d exp=0", rom_addr); end
      step(10'd1010, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd10) begin failures++; $display("FAIL edge_addr got=%0d exp=10", rom_addr); end
      idle(1);
      checks++; if (enemy_on !== 1'b0) begin failures++; $display("FAIL nowrap_on got=%b exp=0", enemy_on); end
      idle(1);
      checks++; if (enemy_on !== 1'b1 || enemy_rgb !== 12'h123) begin failures++; $display("FAIL edge_pix got=%b/%h exp=1/123", enemy_on, enemy_rgb); end
      enemy_x = 10'd100;
   endtask

   task automatic test_reset_dying();
      enemy_x = 10'd100; enemy_y = 10'd50;
      rom_mem[7168] = 12'h00F;
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd7168 || enemy_on !== 1'b1 || enemy_rgb !== 12'h00F) begin failures++; $display("FAIL pre_reset got=%0d/%b/%h exp=7168/1/00f", rom_addr, enemy_on, enemy_rgb); end
      #2 reset = 1'b1;
      #1;
      checks++; if (rom_addr !== 14'd0 || enemy_on !== 1'b0 || enemy_rgb !== 12'h000 || enemy_dead !== 1'b1) begin failures++; $display("FAIL async_reset got=%0d/%b/%h/%b exp=0/0/000/1", rom_addr, enemy_on, enemy_rgb, enemy_dead); end
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      step(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rom_addr !== 14'd0 || enemy_dead !== 1'b1) begin failures++; $display("FAIL post_reset got=%0d/%b exp=0/1", rom_addr, enemy_dead); end
   endtask

   task automatic test_random();
      int bad_addr = 0, bad_pix = 0, bad_dead = 0, bad_state = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            enemy_x = 10'($urandom_range(0, 1023));
            enemy_y = 10'($urandom_range(0, 1023));
         end
         step(10'(int'(enemy_x) + $urandom_range(0, 80) - 8),
              10'(int'(enemy_y) + $urandom_range(0, 70) - 8),
              1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 150) == 0), 1'($urandom_range(0, 60) == 0));
         if (rom_addr !== exp_addr) begin
            bad_addr++;
            if (bad_addr < 4) $display("FAIL rand_addr cyc=%0d got=%0d exp=%0d", i, rom_addr, exp_addr);
         end
         if (enemy_on !== exp_on || enemy_rgb !== exp_rgb) begin
            bad_pix++;
            if (bad_pix < 4) $display("FAIL rand_pix cyc=%0d got=%b/%h exp=%b/%h", i, enemy_on, enemy_rgb, exp_on, exp_rgb);
         end
         if (enemy_dead !== exp_dead) bad_dead++;
         if (int'(state_dbg) != m_mode) bad_state++;
      end
      checks++; if (bad_addr != 0) begin failures++; $display("FAIL rand_addr_total got=%0d exp=0", bad_addr); end
      checks++; if (bad_pix != 0) begin failures++; $display("FAIL rand_pix_total got=%0d exp=0", bad_pix); end
      checks++; if (bad_dead != 0) begin failures++; $display("FAIL rand_dead_total got=%0d exp=0", bad_dead); end
      checks++; if (bad_state != 0) begin failures++; $display("FAIL rand_state_total got=%0d exp=0", bad_state); end
   endtask

   initial begin
      for (int i = 0; i < ROM_WORDS; i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? TRANSPARENT : 12'($urandom);
      model_reset();
      test_reset();
      test_no_spawn();
      test_box();
      test_walk_anim();
      test_transparent();
      test_kill_death();
      test_no_wrap();
      test_reset_dying();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
